// File: rtl/icache_ctrl_fsm_pkg.sv
// Shared constants and types for the instruction-cache control FSM.
// Default geometry mirrors the CPU parameter header.
package icache_ctrl_fsm_pkg;

    localparam int         ICACHE_WAYS      = 2;
    localparam int         ICACHE_SETS      = 256;
    localparam int         ICACHE_BEATS     = 4;
    localparam logic [7:0] ICACHE_LFSR_SEED = 8'hA5;

    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_IDLE   = 3'd1,
        ST_LOOKUP = 3'd2,
        ST_MISS   = 3'd3,
        ST_REFILL = 3'd4,
        ST_WRITE  = 3'd5,
        ST_CACOP  = 3'd6
    } state_e;

    // Index width that never collapses to zero bits.
    function automatic int clog2_min1(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/icache_ctrl_fsm_if.sv
// Handshake bundle between the icache controller and its pipeline / bridge neighbours.
// master = controller side, slave = pipeline, RAMs and bridge side.
interface icache_ctrl_fsm_if
    import icache_ctrl_fsm_pkg::*;
#(
    parameter int WAYS  = ICACHE_WAYS,
    parameter int SETS  = ICACHE_SETS,
    parameter int BEATS = ICACHE_BEATS
) ();
    localparam int WAY_W  = clog2_min1(WAYS);
    localparam int SET_W  = clog2_min1(SETS);
    localparam int BEAT_W = clog2_min1(BEATS);

    logic              stall;
    logic              pipeline_valid;
    logic [WAYS-1:0]   hit;
    logic [WAYS-1:0]   valid_vec;
    logic              memory_ready;
    logic              ret_valid;
    logic              ret_last;
    logic              cacop_valid;

    logic [WAY_W-1:0]  select_way;
    logic              rbuf_we;
    logic              ret_we;
    logic [BEAT_W-1:0] refill_idx;
    logic              pipeline_ready;
    logic [WAYS-1:0]   cache_we;
    logic              valid_wdata;
    logic [SET_W-1:0]  init_set;
    logic              init_busy;
    logic              is_inst_from_mem;
    logic              memory_valid;
    logic              fix_branch;
    logic              cacop_ready;

    modport master (
        input  stall, pipeline_valid, hit, valid_vec, memory_ready,
               ret_valid, ret_last, cacop_valid,
        output select_way, rbuf_we, ret_we, refill_idx, pipeline_ready,
               cache_we, valid_wdata, init_set, init_busy, is_inst_from_mem,
               memory_valid, fix_branch, cacop_ready
    );

    modport slave (
        output stall, pipeline_valid, hit, valid_vec, memory_ready,
               ret_valid, ret_last, cacop_valid,
        input  select_way, rbuf_we, ret_we, refill_idx, pipeline_ready,
               cache_we, valid_wdata, init_set, init_busy, is_inst_from_mem,
               memory_valid, fix_branch, cacop_ready
    );

endinterface

// File: rtl/icache_ctrl_fsm_victim_sel.sv
// Replacement-way picker: lowest invalid way if any, otherwise the low bits
// of a free-running 8-bit LFSR (x^8+x^6+x^5+x^4+1).
module icache_victim_sel
    import icache_ctrl_fsm_pkg::*;
#(
    parameter int         WAYS      = ICACHE_WAYS,
    parameter logic [7:0] LFSR_SEED = ICACHE_LFSR_SEED,
    localparam int        WAY_W     = clog2_min1(WAYS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WAYS-1:0]  valid_vec,
    output logic [WAY_W-1:0] victim
);
    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    // Descending scan so the lowest-index invalid way is the last to win.
    always_comb begin
        victim = lfsr_q[WAY_W-1:0];
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (!valid_vec[i]) begin
                victim = WAY_W'(i);
            end
        end
    end

endmodule

// File: rtl/icache_ctrl_fsm.sv
// N-way instruction-cache control FSM: init sweep, lookup, multi-beat refill,
// line write and index-invalidate. Tag/data RAMs and the return buffer live outside.
module icache_ctrl_fsm
    import icache_ctrl_fsm_pkg::*;
#(
    parameter int         WAYS      = ICACHE_WAYS,
    parameter int         SETS      = ICACHE_SETS,
    parameter int         BEATS     = ICACHE_BEATS,
    parameter logic [7:0] LFSR_SEED = ICACHE_LFSR_SEED
) (
    input  logic               clk,
    input  logic               rst,
    icache_ctrl_fsm_if.master  bus
);
    localparam int WAY_W  = clog2_min1(WAYS);
    localparam int SET_W  = clog2_min1(SETS);
    localparam int BEAT_W = clog2_min1(BEATS);
    localparam logic [SET_W-1:0]  SET_LAST  = SET_W'(SETS - 1);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS - 1);

    state_e            state_q, state_d;
    logic [SET_W-1:0]  set_q, set_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [WAY_W-1:0]  victim_q, victim_d;
    logic              stall_seen_q, stall_seen_d;

    logic [WAY_W-1:0]  victim_pick;
    logic [WAY_W-1:0]  hit_idx;
    logic [WAYS-1:0]   victim_oh;
    logic              lookup_hit;
    logic              line_done;

    icache_victim_sel #(
        .WAYS      (WAYS),
        .LFSR_SEED (LFSR_SEED)
    ) u_victim_sel (
        .clk       (clk),
        .rst       (rst),
        .valid_vec (bus.valid_vec),
        .victim    (victim_pick)
    );

    // hit is one-hot, so OR-ing the indices of set bits is the encoder.
    always_comb begin
        hit_idx = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (bus.hit[i]) begin
                hit_idx = hit_idx | WAY_W'(i);
            end
        end
    end

    for (genvar gi = 0; gi < WAYS; gi++) begin : gen_victim_oh
        assign victim_oh[gi] = (victim_q == WAY_W'(gi));
    end

    assign lookup_hit = bus.pipeline_valid && (|bus.hit);
    // Early ret_last or the final counted beat both close the line.
    assign line_done  = bus.ret_valid && (bus.ret_last || (beat_q == BEAT_LAST));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_INIT;
            set_q        <= '0;
            beat_q       <= '0;
            victim_q     <= '0;
            stall_seen_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            set_q        <= set_d;
            beat_q       <= beat_d;
            victim_q     <= victim_d;
            stall_seen_q <= stall_seen_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        set_d        = set_q;
        beat_d       = beat_q;
        victim_d     = victim_q;
        stall_seen_d = stall_seen_q;
        case (state_q)
            ST_INIT: begin
                set_d = set_q + SET_W'(1);
                if (set_q == SET_LAST) state_d = ST_IDLE;
            end
            ST_IDLE:   state_d = ST_LOOKUP;
            ST_LOOKUP: begin
                if (bus.stall) begin
                    state_d = ST_LOOKUP;
                end else if (bus.cacop_valid) begin
                    state_d = ST_CACOP;
                end else if (bus.pipeline_valid && !lookup_hit) begin
                    victim_d = victim_pick;
                    state_d  = ST_MISS;
                end
            end
            ST_MISS: begin
                if (bus.stall) begin
                    state_d = ST_LOOKUP;
                end else if (bus.memory_ready) begin
                    beat_d       = '0;
                    stall_seen_d = 1'b0;
                    state_d      = ST_REFILL;
                end
            end
            ST_REFILL: begin
                // The bridge cannot abandon a burst, so a stall only suppresses delivery.
                stall_seen_d = stall_seen_q | bus.stall;
                if (bus.ret_valid && (beat_q != BEAT_LAST)) beat_d = beat_q + BEAT_W'(1);
                if (line_done) state_d = (stall_seen_q || bus.stall) ? ST_LOOKUP : ST_WRITE;
            end
            ST_WRITE:  state_d = ST_LOOKUP;
            ST_CACOP:  state_d = ST_LOOKUP;
            default:   state_d = ST_INIT;
        endcase
    end

    always_comb begin
        bus.select_way       = '0;
        bus.rbuf_we          = 1'b0;
        bus.ret_we           = 1'b0;
        bus.refill_idx       = '0;
        bus.pipeline_ready   = 1'b0;
        bus.cache_we         = '0;
        bus.valid_wdata      = 1'b0;
        bus.init_set         = '0;
        bus.init_busy        = 1'b0;
        bus.is_inst_from_mem = 1'b0;
        bus.memory_valid     = 1'b0;
        bus.fix_branch       = 1'b0;
        bus.cacop_ready      = 1'b0;
        case (state_q)
            ST_INIT: begin
                bus.cache_we  = '1;
                bus.init_set  = set_q;
                bus.init_busy = 1'b1;
            end
            ST_IDLE: begin
                bus.rbuf_we    = 1'b1;
                bus.fix_branch = 1'b1;
            end
            ST_LOOKUP: begin
                if (bus.stall) begin
                    bus.rbuf_we = 1'b1;
                end else if (!bus.cacop_valid && lookup_hit) begin
                    bus.select_way     = hit_idx;
                    bus.pipeline_ready = 1'b1;
                    bus.rbuf_we        = 1'b1;
                end
            end
            ST_MISS: bus.memory_valid = !bus.stall;
            ST_REFILL: begin
                bus.refill_idx = beat_q;
                bus.ret_we     = bus.ret_valid;
                if (line_done) begin
                    bus.cache_we    = victim_oh;
                    bus.valid_wdata = 1'b1;
                end
            end
            ST_WRITE: begin
                bus.is_inst_from_mem = 1'b1;
                bus.rbuf_we          = 1'b1;
                bus.pipeline_ready   = !bus.stall;
            end
            ST_CACOP: begin
                bus.cache_we    = '1;
                bus.cacop_ready = 1'b1;
                bus.rbuf_we     = 1'b1;
            end
            default: ;
        endcase
    end

    hit_onehot_a: assert property (@(posedge clk) disable iff (rst) $onehot0(bus.hit));

endmodule

// File: doc/icache_ctrl_fsm.md
Name: icache_ctrl_fsm

Overview:
- Parametrised control FSM for the N-way instruction cache, between the IF-stage request buffer and the AXI-style read bridge.
- Generalises the 2-way, single-beat controller:
  - any power-of-two way count;
  - multi-beat line refill with beat counter;
  - post-reset valid-bit init sweep;
  - CACOP index-invalidate;
  - victim selection that prefers an invalid way, else an LFSR pick.
- Control only: the tag/data RAMs and return buffer are outside this block.

Parameters:
- WAYS, 2, number of ways; power of two, at least 2.
- SETS, 256, number of sets; power of two.
- BEATS, 4, memory beats (32-bit words) per line.
- LFSR_SEED, 8'hA5, nonzero reset value of the 8-bit replacement LFSR.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- stall  in  1  pipeline flush/stall; abandons the current lookup
- pipeline_valid  in  1  IF request valid, address held in rbuf
- hit  in  WAYS  per-way tag-compare hit, one-hot or zero
- valid_vec  in  WAYS  valid bits of the indexed set
- memory_ready  in  1  read-request accepted by the bridge
- ret_valid  in  1  refill beat valid
- ret_last  in  1  final refill beat
- cacop_valid  in  1  index-invalidate request; index taken from rbuf
- select_way  out  WAY_W  way muxed to the instruction output
- rbuf_we  out  1  load next request into rbuf
- ret_we  out  1  write current beat into the return buffer
- refill_idx  out  log2(BEATS)  word index of the current beat
- pipeline_ready  out  1  instruction delivered this cycle
- cache_we  out  WAYS  one-hot line write (tag + valid + data)
- valid_wdata  out  1  valid bit written with cache_we
- init_set  out  log2(SETS)  set index during INIT
- init_busy  out  1  high while INIT runs
- is_inst_from_mem  out  1  instruction sourced from the return buffer
- memory_valid  out  1  read request to the bridge
- fix_branch  out  1  one-cycle redirect-fix pulse
- cacop_ready  out  1  invalidate done

Behaviour:
- WAY_W = max(1, log2(WAYS)).
- Outputs are combinational from state. In every state, any output not listed for that state is 0.
- Reset value of all outputs is 0, except:
  - init_busy = 1 and valid_wdata = 0, since the FSM enters INIT on reset;
  - cache_we = all ones during INIT.
- Registers:
  - state;
  - set counter, reset 0;
  - beat counter, reset 0;
  - victim register, reset 0;
  - LFSR, reset LFSR_SEED; x^8+x^6+x^5+x^4+1, steps every cycle.
- rst (including mid-refill) -> INIT. The bridge is reset by the same rst.
- States:
  - INIT:
    - cache_we = all ones, valid_wdata = 0, init_set = set counter, init_busy = 1.
    - Counter increments each cycle.
    - At SETS-1 -> IDLE.
    - stall is ignored.
  - IDLE:
    - rbuf_we = 1, fix_branch = 1 for one cycle -> LOOKUP.
  - LOOKUP:
    - If cacop_valid (priority over pipeline_valid) -> CACOP.
    - Else if pipeline_valid and |hit:
      - select_way = encode(hit), pipeline_ready = 1, rbuf_we = 1;
      - stay in LOOKUP (back-to-back hits, one per cycle).
    - Else if pipeline_valid and no hit:
      - latch victim: lowest-index way with valid_vec = 0; if all valid, LFSR[WAY_W-1:0];
      - -> MISS.
  - MISS:
    - memory_valid = 1.
    - On memory_ready: clear beat counter -> REFILL.
    - stall before the handshake -> LOOKUP, with no request issued.
  - REFILL:
    - refill_idx = beat counter.
    - On each ret_valid: ret_we = 1, counter +1.
    - On ret_valid with (ret_last or counter == BEATS-1):
      - cache_we[victim] = 1, valid_wdata = 1;
      - -> WRITE, or -> LOOKUP if stall was seen during the refill.
    - A stall during REFILL is recorded in a sticky flag. It does not leave REFILL until the line completes; the line is always written.
  - WRITE:
    - is_inst_from_mem = 1, pipeline_ready = 1, rbuf_we = 1 -> LOOKUP.
    - stall in WRITE -> LOOKUP, with pipeline_ready suppressed.
  - CACOP:
    - cache_we = all ones, valid_wdata = 0, cacop_ready = 1, rbuf_we = 1 -> LOOKUP.
- stall in LOOKUP forces pipeline_ready = 0 and rbuf_we = 1, so the new fetch PC is loaded. The FSM stays in LOOKUP.
- ret_last arriving before BEATS beats is treated as line end. The beat count saturates at BEATS-1.
- hit with more than one bit set is illegal; it is flagged by an assertion only.

Decomposition:
- Shared package constants, in the team's CPU parameter header: state encodings ST_INIT, ST_IDLE, ST_LOOKUP, ST_MISS, ST_REFILL, ST_WRITE, ST_CACOP (3 bits), ICACHE_WAYS, ICACHE_SETS, ICACHE_BEATS.
- One sub-module, icache_victim_sel:
  - holds the LFSR plus the invalid-first priority encoder;
  - ports: clk, rst, valid_vec, victim.

Test Plan:
- Reset, SETS=256 -> init_busy high exactly 256 cycles with init_set 0..255 and cache_we all ones; then one IDLE cycle with fix_branch=1; then LOOKUP.
- WAYS=4, pipeline_valid with hit=4'b0100 on 3 consecutive cycles -> select_way=2, pipeline_ready=1 on all 3 cycles, no memory_valid.
- Miss with valid_vec=4'b1011, bridge ready after 2 cycles, 4 beats with 1 gap:
  - memory_valid for 3 cycles;
  - ret_we on 4 cycles, refill_idx 0..3;
  - cache_we=4'b0100 on beat 3;
  - next cycle is_inst_from_mem=1 and pipeline_ready=1.
- Miss with valid_vec all ones -> victim equals LFSR[1:0] at the miss cycle; check against a reference LFSR model seeded 8'hA5.
- stall asserted at beat 1 of a refill:
  - beats 2..3 are still accepted and the line is written;
  - no pipeline_ready afterwards; returns to LOOKUP.
- cacop_valid and pipeline_valid asserted in the same cycle -> CACOP first: cache_we all ones, valid_wdata=0, cacop_ready=1; the fetch is serviced the next cycle.
